// File: rtl/sender_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sender_arbiter
// Description : Round-robin arbiter that shares one byte-wide UART transmitter
//               between NREQ word producers, serialising 1-4 bytes MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module sender_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [32*NREQ-1:0]        req_data,
    input  logic [2*NREQ-1:0]         req_len,
    input  logic                      sender_ready,
    output logic [7:0]                output_data,
    output logic                      valid,
    output logic [NREQ-1:0]           ack,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int PW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ACK_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [31:0]     shift_buf, shift_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic [7:0]      data_nxt;
    logic            valid_nxt;
    logic [NREQ-1:0] ack_nxt;
    logic            busy_nxt;
    logic [PW-1:0]   grant_nxt;

    logic            found;
    int              idx;
    int              win_idx;
    logic [31:0]     sel_data;
    logic [1:0]      sel_len;
    logic [31:0]     sel_aligned;

    // Round-robin search starting at rr_ptr, then mux out the winner's word.
    always_comb begin
        found   = 1'b0;
        win_idx = 0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!found && (i == idx) && req[i]) begin
                    found   = 1'b1;
                    win_idx = i;
                end
            end
        end

        sel_data = '0;
        sel_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i == win_idx) begin
                sel_data = req_data[32*i +: 32];
                sel_len  = req_len[2*i +: 2];
            end
        end

        // Left-justify the selected low bytes so sending always takes [31:24].
        case (sel_len)
            2'd0:    sel_aligned = {sel_data[7:0],  24'h0};
            2'd1:    sel_aligned = {sel_data[15:0], 16'h0};
            2'd2:    sel_aligned = {sel_data[23:0], 8'h0};
            default: sel_aligned = sel_data;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        shift_nxt  = shift_buf;
        cnt_nxt    = cnt;
        data_nxt   = output_data;
        valid_nxt  = 1'b0;
        ack_nxt    = '0;
        busy_nxt   = busy;
        grant_nxt  = grant_id;

        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = PW'(win_idx);
                    cnt_nxt   = {1'b0, sel_len} + 3'd1;
                    shift_nxt = sel_aligned;
                    busy_nxt  = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (sender_ready) begin
                    data_nxt  = shift_buf[31:24];
                    valid_nxt = 1'b1;
                    shift_nxt = {shift_buf[23:0], 8'h0};
                    cnt_nxt   = cnt - 3'd1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (cnt == 3'd0) begin
                    ack_nxt   = ACK_ONE << grant_id;
                    state_nxt = DONE;
                end else begin
                    state_nxt = SEND;
                end
            end
            DONE: begin
                rr_ptr_nxt = (grant_id == PW'(NREQ - 1)) ? '0 : grant_id + PW'(1);
                busy_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            shift_buf   <= '0;
            cnt         <= '0;
            output_data <= '0;
            valid       <= 1'b0;
            ack         <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            shift_buf   <= shift_nxt;
            cnt         <= cnt_nxt;
            output_data <= data_nxt;
            valid       <= valid_nxt;
            ack         <= ack_nxt;
            busy        <= busy_nxt;
            grant_id    <= grant_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sender_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sender_arbiter
// Description : Scoreboard bench for sender_arbiter (NREQ=2), directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sender_arbiter;

    logic        CLK = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [63:0] req_data;
    logic [3:0]  req_len;
    logic        sender_ready;
    logic [7:0]  output_data;
    logic        valid;
    logic [1:0]  ack;
    logic        busy;
    logic [0:0]  grant_id;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;
    int nvalid = 0;
    int nack   = 0;

    logic [7:0] exp_bytes[$];
    logic [2:0] exp_acks[$];   // {grant_id, ack}
    int         vcyc[$];

    sender_arbiter #(.NREQ(2)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .req_len      (req_len),
        .sender_ready (sender_ready),
        .output_data  (output_data),
        .valid        (valid),
        .ack          (ack),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: pops expectations whenever the DUT presents a byte or an ack.
    always @(negedge CLK) begin
        if (valid) begin
            logic [7:0] eb;
            nvalid = nvalid + 1;
            vcyc.push_back(cyc - t0);
            checks = checks + 1;
            if (exp_bytes.size() == 0) begin
                errors = errors + 1;
                $display("FAIL byte: unexpected byte %02h, none expected", output_data);
            end else begin
                eb = exp_bytes.pop_front();
                if (output_data !== eb) begin
                    errors = errors + 1;
                    $display("FAIL byte: got %02h expected %02h", output_data, eb);
                end
            end
        end
        if (ack != 2'b00) begin
            logic [2:0] ea;
            nack = nack + 1;
            checks = checks + 1;
            if (exp_acks.size() == 0) begin
                errors = errors + 1;
                $display("FAIL ack: unexpected ack %b grant %0d", ack, grant_id);
            end else begin
                ea = exp_acks.pop_front();
                if ({grant_id, ack} !== ea) begin
                    errors = errors + 1;
                    $display("FAIL ack: got grant %0d ack %b expected grant %0d ack %b",
                             grant_id, ack, ea[2], ea[1:0]);
                end
            end
        end
    end

    task automatic cyc1();
        @(negedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Push the n low bytes of v, most significant first.
    task automatic push_bytes(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            exp_bytes.push_back(v[8*i +: 8]);
        end
    endtask

    task automatic wait_nack(input int target, input string name);
        int n;
        n = 0;
        while (nack < target && n < 200) begin
            cyc1();
            n++;
        end
        if (nack < target) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: timeout, acks %0d need %0d", name, nack, target);
        end
    endtask

    task automatic wait_nvalid(input int target, input string name);
        int n;
        n = 0;
        while (nvalid < target && n < 200) begin
            cyc1();
            n++;
        end
        if (nvalid < target) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: timeout, bytes %0d need %0d", name, nvalid, target);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [1:0] dropped;

        reset        = 1'b1;
        req          = 2'b00;
        req_data     = '0;
        req_len      = '0;
        sender_ready = 1'b1;
        repeat (3) cyc1();
        chk("reset_outputs", {output_data, valid, ack, busy, grant_id}, 0);
        reset = 1'b0;
        cyc1();

        // Single 4-byte word with exact cycle timing
        push_bytes(32'hDEADBEEF, 4);
        exp_acks.push_back({1'b0, 2'b01});
        req_data[31:0] = 32'hDEADBEEF;
        req_len[1:0]   = 2'd3;
        req            = 2'b01;
        t0             = cyc;
        vcyc.delete();
        for (int rel = 1; rel <= 10; rel++) begin
            cyc1();
            if (rel == 1) chk("t1_busy_rise", busy, 1);
            if (rel == 9) begin
                chk("t1_ack_cycle", ack, 2'b01);
                req = 2'b00;
            end
            if (rel == 10) chk("t1_busy_fall", busy, 0);
        end
        chk("t1_nbytes", vcyc.size(), 4);
        for (int i = 0; i < vcyc.size() && i < 4; i++) begin
            chk("t1_valid_cycle", vcyc[i], 2 * (i + 1));
        end

        // Short word from requester 1
        base = nack;
        push_bytes(32'h00005678, 2);
        exp_acks.push_back({1'b1, 2'b10});
        req_data[63:32] = 32'h12345678;
        req_len[3:2]    = 2'd1;
        req             = 2'b10;
        wait_nack(base + 1, "t2_ack");
        req = 2'b00;
        cyc1();
        chk("t2_grant_id", grant_id, 1);

        // Contention: grant order 0,1,0,1
        base     = nack;
        req_data = {32'h0000B1B2, 32'h000000A0};
        req_len  = {2'd1, 2'd0};
        for (int t = 0; t < 2; t++) begin
            push_bytes(32'h000000A0, 1);
            exp_acks.push_back({1'b0, 2'b01});
            push_bytes(32'h0000B1B2, 2);
            exp_acks.push_back({1'b1, 2'b10});
        end
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_nack(base + t + 1, "t3_ack");
            dropped = ack;
            req = req & ~dropped;
            cyc1();
            cyc1();
            if (t < 2) req = req | dropped;
        end
        chk("t3_req_cleared", req, 2'b00);

        // Backpressure after the first byte
        base = nvalid;
        push_bytes(32'hA1B2C3D4, 4);
        exp_acks.push_back({1'b0, 2'b01});
        req_data[31:0] = 32'hA1B2C3D4;
        req_len[1:0]   = 2'd3;
        req            = 2'b01;
        wait_nvalid(base + 1, "t4_first");
        sender_ready = 1'b0;
        repeat (20) cyc1();
        chk("t4_hold_no_valid", nvalid - base, 1);
        chk("t4_hold_busy", busy, 1);
        sender_ready = 1'b1;
        cyc1();
        chk("t4_resume", nvalid - base, 2);
        wait_nack(nack + 1, "t4_ack");
        req = 2'b00;
        cyc1();

        // Reset mid-transfer after the 2nd byte (rr_ptr is 1 at this point)
        base = nvalid;
        push_bytes(32'h0000CAFE, 2);
        req_data[63:32] = 32'hCAFEF00D;
        req_len[3:2]    = 2'd3;
        req             = 2'b10;
        wait_nvalid(base + 2, "t5_two_bytes");
        reset = 1'b1;
        req   = 2'b00;
        base  = nack;
        cyc1();
        chk("t5_reset_outputs", {output_data, valid, ack, busy, grant_id}, 0);
        reset = 1'b0;
        repeat (3) cyc1();
        chk("t5_no_ack", nack - base, 0);
        push_bytes(32'h01020304, 4);
        exp_acks.push_back({1'b0, 2'b01});
        req_data = {32'h00000099, 32'h01020304};
        req_len  = {2'd0, 2'd3};
        req      = 2'b11;
        wait_nack(base + 1, "t5_ack");
        req = 2'b00;
        cyc1();

        // Data/length change the cycle after grant
        base = nack;
        push_bytes(32'h00223344, 3);
        exp_acks.push_back({1'b0, 2'b01});
        req_data[31:0] = 32'h11223344;
        req_len[1:0]   = 2'd2;
        req            = 2'b01;
        cyc1();
        req_data[31:0] = 32'hFFFFFFFF;
        req_len[1:0]   = 2'd0;
        wait_nack(base + 1, "t6_ack");
        req = 2'b00;

        repeat (5) cyc1();
        chk("end_bytes_left", exp_bytes.size(), 0);
        chk("end_acks_left", exp_acks.size(), 0);
        chk("end_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
